// File: rtl/sort6_pkg.sv
// Shared definitions for the sort6 sequential sorter.
// Holds the default block geometry, the derived counter width and sort
// duration, and the FSM state encoding used by sort6_sequencer.
package sort6_pkg;

    localparam int unsigned N_DEFAULT     = 8;
    localparam int unsigned DEPTH_DEFAULT = 6;
    localparam int unsigned CNT_W         = $clog2(DEPTH_DEFAULT);
    localparam int unsigned SORT_CYCLES   = (DEPTH_DEFAULT - 1) * (DEPTH_DEFAULT - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sort6_sequencer_comparator.sv
// Unsigned magnitude comparator producing less / equal / greater flags.
// Ports:
//   a, b : N-bit unsigned operands
//   l    : a <  b
//   e    : a == b
//   g    : a >  b
// Exactly one flag is high for any pair of operands.
module comparator #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         l,
    output logic         e,
    output logic         g
);

    assign l = (a < b);
    assign e = (a == b);
    assign g = (a > b);

endmodule

// File: rtl/sort6_sequencer.sv
// Sequential block sorter: loads DEPTH unsigned words over a valid/ready
// stream, sorts them in place with a fixed-schedule bubble sort (one
// compare per cycle through a single comparator), then streams them out in
// ascending order.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (ready only while loading)
//   in_data             : N-bit input word
//   out_valid/out_ready : output handshake (valid only while draining)
//   out_data            : N-bit sorted word, ascending
//   out_last            : marks the largest (final) word of the block
//   busy                : high while sorting or draining
module sort6_sequencer
    import sort6_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int unsigned   CW            = $clog2(DEPTH);
    localparam logic [CW-1:0] IDX_LAST      = CW'(DEPTH - 1);
    localparam logic [CW-1:0] IDX_PAIR_LAST = CW'(DEPTH - 2);

    state_e state_q, state_d;

    logic [CW-1:0] wr_idx_q, wr_idx_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic [CW-1:0] pair_q,   pair_d;
    logic [CW-1:0] pass_q,   pass_d;

    logic [N-1:0] mem_q [DEPTH];

    logic [CW-1:0] pair_hi;
    logic [N-1:0]  cmp_a, cmp_b;
    logic          cmp_l, cmp_e, cmp_g;
    logic          load_we;
    logic          swap_en;

    // Compare the current adjacent pair; only "greater" causes a swap so
    // equal words keep their relative order.
    assign pair_hi = pair_q + CW'(1);
    assign cmp_a   = mem_q[pair_q];
    assign cmp_b   = mem_q[pair_hi];

    comparator #(
        .N (N)
    ) u_cmp (
        .a (cmp_a),
        .b (cmp_b),
        .l (cmp_l),
        .e (cmp_e),
        .g (cmp_g)
    );

    assign load_we = (state_q == ST_LOAD) && in_valid;
    assign swap_en = (state_q == ST_SORT) && cmp_g;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            pair_q   <= '0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            pair_q   <= pair_d;
            pass_q   <= pass_d;
        end
    end

    // Next-state and counter advance.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        pair_d   = pair_q;
        pass_d   = pass_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    if (wr_idx_q == IDX_LAST) begin
                        wr_idx_d = '0;
                        pair_d   = '0;
                        pass_d   = '0;
                        state_d  = ST_SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + CW'(1);
                    end
                end
            end
            ST_SORT: begin
                // DEPTH-1 passes of DEPTH-1 compares, no early exit.
                if (pair_q == IDX_PAIR_LAST) begin
                    pair_d = '0;
                    if (pass_q == IDX_PAIR_LAST) begin
                        pass_d   = '0;
                        rd_idx_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        pass_d = pass_q + CW'(1);
                    end
                end else begin
                    pair_d = pair_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == IDX_LAST) begin
                        rd_idx_d = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Handshake and status decode from registered state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
            end
            ST_SORT: begin
                busy = 1'b1;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (rd_idx_q == IDX_LAST);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign out_data = mem_q[rd_idx_q];

    // Block storage: written while loading, pair-swapped while sorting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                mem_q[k] <= '0;
            end
        end else if (load_we) begin
            mem_q[wr_idx_q] <= in_data;
        end else if (swap_en) begin
            mem_q[pair_q]  <= cmp_b;
            mem_q[pair_hi] <= cmp_a;
        end
    end

    // Comparator flags are mutually exclusive; indices stay inside the block.
    cmp_flags_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot({cmp_l, cmp_e, cmp_g}));

    idx_in_range_a: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_idx_q <= IDX_LAST) && (rd_idx_q <= IDX_LAST));

endmodule
